// File: rtl/button_event_arbiter_pkg.sv
// Shared types, constants and the round-robin helper for the push-button front end.
package button_event_arbiter_pkg;

    localparam int MAX_BTN       = 8;
    localparam int DB_CYCLES_SYN = 500000;
    localparam int DB_CYCLES_SIM = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } arb_state_t;

    // First set request strictly after 'last', wrapping modulo n; the downward
    // scan lets the smallest offset win.
    function automatic int rr_next(input logic [MAX_BTN-1:0] req, input int last, input int n);
        int idx;
        rr_next = 0;
        for (int off = n; off >= 1; off--) begin
            idx = (last + off) % n;
            if (req[idx[2:0]]) rr_next = idx;
        end
    endfunction

endpackage

// File: rtl/button_event_arbiter_debounce.sv
// One button channel: synchronizer, debounce counter, accepted level and press pulse.
module debounce_channel
    import button_event_arbiter_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_SYN,
    parameter int CNT_W     = $clog2(DB_CYCLES)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    input  logic enable,
    output logic level,
    output logic rise
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             synced;
    logic [CNT_W-1:0] cnt;

    synchronizer u_sync (
        .clk (clk),
        .d   (raw),
        .q   (synced)
    );

    assign rise = enable && synced && !level && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (!enable || synced == level) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            level <= synced;
            cnt   <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/synchronizer.sv
// Two-flop synchronizer for a single asynchronous level; deliberately unreset.
module synchronizer (
    input  logic clk,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        meta <= d;
        q    <= meta;
    end

endmodule

// File: rtl/button_event_arbiter.sv
// Push-button front end: debounced channels feed per-channel pending flags that a
// round-robin arbiter offers one at a time over a valid/ready handshake.
module button_event_arbiter
    import button_event_arbiter_pkg::*;
#(
    parameter int N_BTN     = 4,
    parameter int DB_CYCLES = DB_CYCLES_SYN,
    parameter int CNT_W     = $clog2(DB_CYCLES),
    parameter int ID_W      = $clog2(N_BTN)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic             evt_ready,
    output logic             evt_valid,
    output logic [ID_W-1:0]  evt_id,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] overflow
);

    logic [1:0]       warm;
    logic [N_BTN-1:0] rise;
    logic [N_BTN-1:0] pending;
    logic [N_BTN-1:0] clr_mask;
    logic [ID_W-1:0]  last_grant;
    logic             handshake;
    arb_state_t       state;

    // Synchronizers are unreset, so counting waits until they hold two fresh samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) warm <= 2'b00;
        else          warm <= {warm[0], 1'b1};
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        debounce_channel #(
            .DB_CYCLES (DB_CYCLES),
            .CNT_W     (CNT_W)
        ) u_chan (
            .clk     (clk),
            .reset_n (reset_n),
            .raw     (btn_raw[i]),
            .enable  (warm[1]),
            .level   (btn_level[i]),
            .rise    (rise[i])
        );
    end

    assign handshake = (state == OFFER) && evt_valid && evt_ready;

    always_comb begin
        clr_mask = '0;
        if (handshake) clr_mask[evt_id] = 1'b1;
    end

    // A press arriving on the handshake edge re-arms the flag instead of overflowing.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending  <= '0;
            overflow <= '0;
        end else begin
            pending  <= (pending & ~clr_mask) | rise;
            overflow <= overflow | (rise & pending & ~clr_mask);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            evt_valid  <= 1'b0;
            evt_id     <= '0;
            last_grant <= ID_W'(N_BTN - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (|pending) begin
                        evt_id    <= ID_W'(rr_next(MAX_BTN'(pending), int'(last_grant), N_BTN));
                        evt_valid <= 1'b1;
                        state     <= OFFER;
                    end
                end
                OFFER: begin
                    if (evt_ready) begin
                        last_grant <= evt_id;
                        evt_valid  <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    evt_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_event_arbiter.sv
// Scoreboard bench for button_event_arbiter with the short simulation debounce time.
module tb_button_event_arbiter;

    localparam int N_BTN = 4;
    localparam int DB    = 4;
    localparam int ID_W  = 2;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [N_BTN-1:0] btn_raw;
    logic             evt_ready;
    logic             evt_valid;
    logic [ID_W-1:0]  evt_id;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] overflow;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    logic            prev_valid = 1'b0;
    logic            prev_ready = 1'b0;
    logic [ID_W-1:0] prev_id    = '0;

    always #5 clk = ~clk;

    button_event_arbiter #(
        .N_BTN     (N_BTN),
        .DB_CYCLES (DB)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .btn_raw   (btn_raw),
        .evt_ready (evt_ready),
        .evt_valid (evt_valid),
        .evt_id    (evt_id),
        .btn_level (btn_level),
        .overflow  (overflow)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [N_BTN-1:0] btn, input logic ready);
        btn_raw   = btn;
        evt_ready = ready;
    endtask

    task automatic applyReset();
        reset_n = 1'b0;
        step(3);
        reset_n = 1'b1;
        step(2);
    endtask

    task automatic waitValid(input int max_cycles);
        int n = 0;
        while (!evt_valid && n < max_cycles) begin
            step(1);
            n++;
        end
        checkOutput("wait_valid", 32'(evt_valid), 32'd1);
    endtask

    // Monitor: pops the scoreboard on each handshake and checks the offer is held under backpressure.
    always @(negedge clk) begin
        int e;
        if (!reset_n) begin
            prev_valid = 1'b0;
        end else begin
            if (prev_valid && !prev_ready && evt_valid)
                checkOutput("held_id", 32'(evt_id), 32'(prev_id));
            if (evt_valid && evt_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_event", 32'(evt_id), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("event_id", 32'(evt_id), 32'(e));
                end
            end
            prev_valid = evt_valid;
            prev_ready = evt_ready;
            prev_id    = evt_id;
        end
    end

    initial begin
        reset_n = 1'b0;
        applyStimulus('0, 1'b0);
        step(3);
        checkOutput("rst_valid", 32'(evt_valid), 32'd0);
        checkOutput("rst_id", 32'(evt_id), 32'd0);
        checkOutput("rst_level", 32'(btn_level), 32'd0);
        checkOutput("rst_overflow", 32'(overflow), 32'd0);
        reset_n = 1'b1;
        step(3);

        // Single press latency on channel 2
        $display("[TB] press latency");
        exp_q.push_back(2);
        applyStimulus(4'b0100, 1'b1);
        step(5);
        checkOutput("lat_level_early", 32'(btn_level), 32'd0);
        step(1);
        checkOutput("lat_level", 32'(btn_level), 32'b0100);
        checkOutput("lat_valid_early", 32'(evt_valid), 32'd0);
        step(1);
        checkOutput("lat_valid", 32'(evt_valid), 32'd1);
        checkOutput("lat_id", 32'(evt_id), 32'd2);
        step(1);
        checkOutput("lat_valid_drop", 32'(evt_valid), 32'd0);
        applyStimulus('0, 1'b1);
        step(10);

        // Three-cycle glitch on channel 1
        $display("[TB] glitch rejection");
        applyStimulus(4'b0010, 1'b1);
        step(3);
        applyStimulus('0, 1'b1);
        step(10);
        checkOutput("glitch_level", 32'(btn_level), 32'd0);
        checkOutput("glitch_valid", 32'(evt_valid), 32'd0);
        checkOutput("glitch_overflow", 32'(overflow), 32'd0);

        // Fairness: all channels at once, then 0 and 3 after grant wraps
        $display("[TB] round-robin fairness");
        applyReset();
        for (int i = 0; i < N_BTN; i++) exp_q.push_back(i);
        applyStimulus(4'b1111, 1'b1);
        waitValid(20);
        for (int i = 0; i < N_BTN; i++) begin
            checkOutput("rr_valid_hi", 32'(evt_valid), 32'd1);
            step(1);
            checkOutput("rr_valid_lo", 32'(evt_valid), 32'd0);
            step(1);
        end
        applyStimulus('0, 1'b1);
        step(10);
        exp_q.push_back(0);
        exp_q.push_back(3);
        applyStimulus(4'b1001, 1'b1);
        waitValid(20);
        checkOutput("wrap_first", 32'(evt_id), 32'd0);
        step(2);
        checkOutput("wrap_second", 32'(evt_id), 32'd3);
        checkOutput("wrap_valid", 32'(evt_valid), 32'd1);
        step(1);
        applyStimulus('0, 1'b1);
        step(10);

        // Backpressure with a dropped second press on channel 0
        $display("[TB] backpressure and overflow");
        exp_q.push_back(0);
        applyStimulus(4'b0001, 1'b0);
        waitValid(20);
        checkOutput("bp_id", 32'(evt_id), 32'd0);
        applyStimulus('0, 1'b0);
        step(8);
        checkOutput("bp_overflow_none", 32'(overflow), 32'd0);
        applyStimulus(4'b0001, 1'b0);
        step(8);
        checkOutput("bp_overflow", 32'(overflow), 32'b0001);
        checkOutput("bp_valid_held", 32'(evt_valid), 32'd1);
        checkOutput("bp_id_held", 32'(evt_id), 32'd0);
        applyStimulus(4'b0001, 1'b1);
        step(1);
        applyStimulus(4'b0001, 1'b0);
        step(4);
        checkOutput("bp_single_event", 32'(evt_valid), 32'd0);

        // Second channel-1 press landing exactly on the handshake edge
        $display("[TB] set/clear collision");
        applyStimulus('0, 1'b0);
        applyReset();
        exp_q.push_back(1);
        exp_q.push_back(1);
        applyStimulus(4'b0010, 1'b0);
        step(7);
        checkOutput("col_offer", 32'(evt_valid), 32'd1);
        applyStimulus(4'b0000, 1'b0);
        step(7);
        checkOutput("col_released", 32'(btn_level), 32'd0);
        applyStimulus(4'b0010, 1'b0);
        step(5);
        applyStimulus(4'b0010, 1'b1);
        step(1);
        applyStimulus(4'b0010, 1'b0);
        checkOutput("col_valid_gap", 32'(evt_valid), 32'd0);
        checkOutput("col_level", 32'(btn_level), 32'b0010);
        checkOutput("col_overflow", 32'(overflow), 32'd0);
        step(1);
        checkOutput("col_reoffer", 32'(evt_valid), 32'd1);
        checkOutput("col_reoffer_id", 32'(evt_id), 32'd1);
        applyStimulus(4'b0010, 1'b1);
        step(1);
        checkOutput("col_done", 32'(evt_valid), 32'd0);

        // Reset during an offer with channel 2 held through release
        $display("[TB] reset mid-offer");
        applyStimulus(4'b0100, 1'b0);
        waitValid(20);
        checkOutput("rmo_id", 32'(evt_id), 32'd2);
        reset_n = 1'b0;
        #1;
        checkOutput("rmo_valid", 32'(evt_valid), 32'd0);
        checkOutput("rmo_level", 32'(btn_level), 32'd0);
        checkOutput("rmo_overflow", 32'(overflow), 32'd0);
        step(3);
        reset_n = 1'b1;
        exp_q.push_back(2);
        step(5);
        checkOutput("rmo_level_early", 32'(btn_level), 32'd0);
        step(1);
        checkOutput("rmo_level_rise", 32'(btn_level), 32'b0100);
        checkOutput("rmo_valid_early", 32'(evt_valid), 32'd0);
        step(1);
        checkOutput("rmo_valid_rise", 32'(evt_valid), 32'd1);
        applyStimulus(4'b0100, 1'b1);
        step(1);
        applyStimulus('0, 1'b0);
        checkOutput("rmo_consumed", 32'(evt_valid), 32'd0);
        step(3);

        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
